serial_comparator_ctrl: RTL and testbench



---
 rtl/serial_comparator_ctrl_if.sv | 42 ++++
 rtl/serial_comparator_ctrl.sv | 146 ++++++++++++++
 tb/tb_serial_comparator_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/serial_comparator_ctrl_if.sv
// rtl/serial_comparator_ctrl_if.sv - request/result bundle for the serial magnitude comparator
//
// Purpose: groups the start handshake, operands and result signals of
// serial_comparator_ctrl so requester and controller connect through one port.
//
// Signals:
//   start        requester -> ctrl  request a compare (taken only while ready=1)
//   A, B         requester -> ctrl  WIDTH-bit unsigned operands, sampled on accepted start
//   ready        ctrl -> requester  controller idle, start will be accepted
//   busy         ctrl -> requester  compare in progress
//   done         ctrl -> requester  one-cycle pulse, results valid
//   AgreaterB    ctrl -> requester  A > B
//   AlessB       ctrl -> requester  A < B
//   AequalB      ctrl -> requester  A == B
//   slices_used  ctrl -> requester  2-bit slices examined by the last compare
//
// Modports: master = requester side, slave = controller side.
interface serial_comparator_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH/2) + 1
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             done;
  logic             AgreaterB;
  logic             AlessB;
  logic             AequalB;
  logic [CW-1:0]    slices_used;

  modport master (
    output start, A, B,
    input  ready, busy, done, AgreaterB, AlessB, AequalB, slices_used
  );

  modport slave (
    input  start, A, B,
    output ready, busy, done, AgreaterB, AlessB, AequalB, slices_used
  );
endinterface

// File: rtl/serial_comparator_ctrl.sv
// rtl/serial_comparator_ctrl.sv - MSB-first serial magnitude comparator using one 2-bit slice
//
// Purpose: captures A/B on an accepted start, then examines one 2-bit slice per
// clock from the most significant slice down. Stops at the first unequal slice
// (or after slice 0) and reports greater/less/equal with a one-cycle done pulse.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   serial_comparator_ctrl_if.slave (start/A/B in; ready/busy/done,
//         result flags and slices_used out)
//
// WIDTH must be even and >= 2.
module serial_comparator_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH/2) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_comparator_ctrl_if.slave  bus
);

  localparam int NSLICE = WIDTH / 2;
  // idx needs at least one bit even when there is a single slice
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    slices_q;
  logic             gt_q;
  logic             lt_q;
  logic             eq_q;

  logic [1:0]       a_sl;
  logic [1:0]       b_sl;
  logic             ready_c;
  logic             busy_c;
  logic             done_c;

  // Slice currently under examination: bits [2*idx+1 : 2*idx]
  assign a_sl = a_reg[{idx, 1'b0} +: 2];
  assign b_sl = b_reg[{idx, 1'b0} +: 2];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        // Early exit on the first differing slice, otherwise finish after slice 0
        if ((a_sl != b_sl) || (idx == '0)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE:    ready_c = 1'b1;
      COMPARE: busy_c  = 1'b1;
      DONE:    done_c  = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  // Operand capture, slice walk and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      idx      <= '0;
      slices_q <= '0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg    <= bus.A;
            b_reg    <= bus.B;
            idx      <= IW'(NSLICE - 1);
            slices_q <= '0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
          end
        end
        COMPARE: begin
          slices_q <= slices_q + CW'(1);
          if (a_sl > b_sl) begin
            gt_q <= 1'b1;
          end else if (a_sl < b_sl) begin
            lt_q <= 1'b1;
          end else if (idx == '0) begin
            eq_q <= 1'b1;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: begin
          // DONE: results hold until the next accepted start
        end
      endcase
    end
  end

  assign bus.ready       = ready_c;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.AgreaterB   = gt_q;
  assign bus.AlessB      = lt_q;
  assign bus.AequalB     = eq_q;
  assign bus.slices_used = slices_q;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// tb/tb_serial_comparator_ctrl.sv - self-checking bench for serial_comparator_ctrl
module tb_serial_comparator_ctrl;

  localparam int WIDTH  = 8;
  localparam int NSLICE = WIDTH / 2;
  localparam int CW     = $clog2(WIDTH/2) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_comparator_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  serial_comparator_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slices examined: the slice holding the most significant differing bit,
  // counted from the MSB slice; all slices when the operands are equal.
  function automatic int exp_slices(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    x = a ^ b;
    if (x == '0) return NSLICE;
    for (int p = WIDTH - 1; p >= 0; p--) begin
      if (x[p]) return NSLICE - p / 2;
    end
    return NSLICE;
  endfunction

  // {ready, busy, done, gt, lt, eq, slices_used}
  function automatic logic [31:0] status();
    return 32'({bus.ready, bus.busy, bus.done, bus.AgreaterB, bus.AlessB,
                bus.AequalB, bus.slices_used});
  endfunction

  localparam logic [31:0] RESET_STATUS = 32'(1) << (5 + CW);

  // One compare. lat counts clock edges from the start-sampling edge (=1) to
  // the first edge after which done is seen. With b2b the task returns in the
  // done cycle so the next call asserts start in the following IDLE cycle.
  task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input bit disturb, input bit b2b, input string tag);
    int k, lat, busy_n, done_n, limit;
    k      = exp_slices(a, b);
    lat    = 0;
    busy_n = 0;
    done_n = 0;
    limit  = NSLICE + 4;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (lat == 0) lat = i;
      end
      @(negedge clk);
      if (i == 1 && disturb) begin
        bus.start = 1'b1;
        bus.A     = '1;
        bus.B     = '0;
      end else begin
        bus.start = 1'b0;
        if (disturb) begin
          bus.A = WIDTH'($urandom);
          bus.B = WIDTH'($urandom);
        end
      end
      if (b2b && done_n != 0) break;
    end
    chk({tag, "_done_cnt"}, 32'(done_n), 32'd1);
    chk({tag, "_latency"},  32'(lat),    32'(k + 1));
    chk({tag, "_busy_cyc"}, 32'(busy_n), 32'(k));
    chk({tag, "_flags"}, 32'({bus.AgreaterB, bus.AlessB, bus.AequalB}),
        32'({a > b, a < b, a == b}));
    chk({tag, "_slices"}, 32'(bus.slices_used), 32'(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_n;
    logic [WIDTH-1:0] a, b;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_status", status(), RESET_STATUS);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_status", status(), RESET_STATUS);

    run(8'hC3, 8'h43, 1'b0, 1'b0, "msb_gt");
    run(8'h5A, 8'h5B, 1'b0, 1'b0, "lsb_lt");
    run(8'hA5, 8'hA5, 1'b0, 1'b0, "equal");
    run(8'h00, 8'h03, 1'b1, 1'b0, "busy_start");

    // rst in the second COMPARE cycle abandons the compare
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'h01;
    bus.B     = 8'h02;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset_status", status(), RESET_STATUS);
    @(negedge clk);
    rst    = 1'b0;
    done_n = 0;
    repeat (NSLICE + 3) begin
      @(posedge clk);
      #1;
      if (bus.done) done_n++;
    end
    chk("mid_reset_no_done", 32'(done_n), 32'd0);

    // rst and start together: rst wins
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 8'hFF;
    bus.B     = 8'h00;
    @(posedge clk);
    #1;
    chk("rst_start_status", status(), RESET_STATUS);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_start_idle", status(), RESET_STATUS);

    run(8'h80, 8'h7F, 1'b0, 1'b0, "after_rst");

    // back-to-back: each start issued in the IDLE cycle right after done
    for (int n = 0; n < 8; n++) begin
      a = WIDTH'($urandom);
      b = (n % 3 == 0) ? a : WIDTH'($urandom);
      run(a, b, 1'b0, 1'b1, $sformatf("b2b%0d", n));
    end

    // randomized, biased toward close operands to spread slice counts
    for (int n = 0; n < 20; n++) begin
      a = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: b = WIDTH'($urandom);
      endcase
      run(a, b, n[0], 1'b0, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
